// File: rtl/dsp_wdata_channel_pkg.sv
// Shared W-channel types: skid-state encoding, slave-index width and W entry packing.
// Optional strobe storage is enabled by defining DSP_WDATA_STRB_EN.
package dsp_wdata_channel_pkg;

`ifdef DSP_WDATA_STRB_EN
   localparam bit STRB_EN = 1'b1;
`else
   localparam bit STRB_EN = 1'b0;
`endif

   // Encoding doubles as the buffered-beat count.
   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

   function automatic int slv_id_w(input int slv_amt);
      return (slv_amt > 1) ? $clog2(slv_amt) : 1;
   endfunction

   // Entry layout, MSB first: {slv_id, last, strb (optional), data}.
   function automatic int w_entry_w(input int id_w, input int data_w);
      return id_w + 1 + (STRB_EN ? data_w / 8 : 0) + data_w;
   endfunction

endpackage

// File: rtl/dsp_wdata_channel_if.sv
// W-channel bundle: master-side beats, address-dispatcher tag, per-slave outputs.
// Strobe signals exist only when DSP_WDATA_STRB_EN is defined.
interface dsp_wdata_channel_if
   import dsp_wdata_channel_pkg::*;
#(
   parameter int SLV_AMT    = 2,
   parameter int SLV_ID_W   = slv_id_w(SLV_AMT),
   parameter int DATA_WIDTH = 32
) ();

   logic [DATA_WIDTH-1:0]         m_WDATA_i;
   logic                          m_WLAST_i;
   logic                          m_WVALID_i;
   logic                          m_WREADY_o;
   logic [SLV_ID_W-1:0]           dsp_xADDR_slv_id_i;
   logic                          dsp_xADDR_disable_i;
   logic [SLV_AMT-1:0]            sa_WREADY_i;
   logic [DATA_WIDTH*SLV_AMT-1:0] sa_WDATA_o;
   logic [SLV_AMT-1:0]            sa_WLAST_o;
   logic [SLV_AMT-1:0]            sa_WVALID_o;
   logic [1:0]                    dsp_WDATA_pend_o;
`ifdef DSP_WDATA_STRB_EN
   logic [DATA_WIDTH/8-1:0]         m_WSTRB_i;
   logic [DATA_WIDTH/8*SLV_AMT-1:0] sa_WSTRB_o;
`endif

   // Handshakes: a beat transfers on a cycle where valid and ready are both high;
   // valid never waits for ready, and a raised valid holds its payload until transfer.
   modport slave (
`ifdef DSP_WDATA_STRB_EN
      input  m_WSTRB_i,
      output sa_WSTRB_o,
`endif
      input  m_WDATA_i, m_WLAST_i, m_WVALID_i,
      output m_WREADY_o,
      input  dsp_xADDR_slv_id_i, dsp_xADDR_disable_i,
      input  sa_WREADY_i,
      output sa_WDATA_o, sa_WLAST_o, sa_WVALID_o, dsp_WDATA_pend_o
   );

   modport master (
`ifdef DSP_WDATA_STRB_EN
      output m_WSTRB_i,
      input  sa_WSTRB_o,
`endif
      output m_WDATA_i, m_WLAST_i, m_WVALID_i,
      input  m_WREADY_o,
      output dsp_xADDR_slv_id_i, dsp_xADDR_disable_i,
      output sa_WREADY_i,
      input  sa_WDATA_o, sa_WLAST_o, sa_WVALID_o, dsp_WDATA_pend_o
   );

endinterface

// File: rtl/dsp_wdata_channel_skid_buffer_2.sv
// Generic 2-entry valid/ready buffer; the registered state is also the beat count.
module dsp_wdata_channel_skid_buffer_2
   import dsp_wdata_channel_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   output logic             o_full,
   output logic             o_pop_valid,
   input  logic             i_pop_ready,
   output logic [WIDTH-1:0] o_pop_data,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   skid_state_e      r_state;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push & (r_state != SKID_FULL);
   assign w_pop  = (r_state != SKID_EMPTY) & i_pop_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= SKID_EMPTY;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         case (r_state)
            SKID_EMPTY: begin
               if (w_push) begin
                  r_state  <= SKID_ONE;
                  r_wr_ptr <= ~r_wr_ptr;
               end
            end
            SKID_ONE: begin
               if (w_push) r_wr_ptr <= ~r_wr_ptr;
               if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
               if (w_push && !w_pop)      r_state <= SKID_FULL;
               else if (w_pop && !w_push) r_state <= SKID_EMPTY;
            end
            SKID_FULL: begin
               if (w_pop) begin
                  r_state  <= SKID_ONE;
                  r_rd_ptr <= ~r_rd_ptr;
               end
            end
            default: r_state <= SKID_EMPTY;
         endcase
      end
   end

   // Payload storage is intentionally left unreset.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_full      = (r_state == SKID_FULL);
   assign o_pop_valid = (r_state != SKID_EMPTY);
   assign o_pop_data  = r_mem[r_rd_ptr];
   assign o_count     = r_state;

endmodule

// File: rtl/dsp_wdata_channel.sv
// Tags master W beats with the address dispatcher's slave ID, buffers them two deep
// and steers them one-hot to the per-slave arbiters. Strobes: define DSP_WDATA_STRB_EN.
module dsp_wdata_channel
   import dsp_wdata_channel_pkg::*;
#(
   parameter int SLV_AMT    = 2,
   parameter int SLV_ID_W   = slv_id_w(SLV_AMT),
   parameter int DATA_WIDTH = 32,
   parameter int BUF_DEPTH  = 2
) (
   input  logic                ACLK_i,
   input  logic                ARESETn_i,
   dsp_wdata_channel_if.slave  bus
);

   localparam int ENTRY_W = w_entry_w(SLV_ID_W, DATA_WIDTH);

   if (BUF_DEPTH != 2) begin : g_bad_depth
      $error("dsp_wdata_channel supports BUF_DEPTH == 2 only");
   end

   logic                  w_ready;
   logic                  w_push;
   logic                  w_full;
   logic                  w_head_valid;
   logic                  w_sel_ready;
   logic [ENTRY_W-1:0]    w_push_entry;
   logic [ENTRY_W-1:0]    w_head;
   logic [SLV_ID_W-1:0]   w_head_id;
   logic                  w_head_last;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic [SLV_AMT-1:0]    w_onehot;
   logic [1:0]            w_count;

   // Acceptance ignores WVALID so the master never sees ready depend on its own valid.
   assign w_ready        = ~w_full & ~bus.dsp_xADDR_disable_i;
   assign w_push         = bus.m_WVALID_i & w_ready;
   assign bus.m_WREADY_o = w_ready;

`ifdef DSP_WDATA_STRB_EN
   localparam int STRB_W = DATA_WIDTH / 8;
   logic [STRB_W-1:0] w_head_strb;

   assign w_push_entry   = {bus.dsp_xADDR_slv_id_i, bus.m_WLAST_i, bus.m_WSTRB_i, bus.m_WDATA_i};
   assign w_head_strb    = w_head[DATA_WIDTH +: STRB_W];
   assign bus.sa_WSTRB_o = {SLV_AMT{w_head_strb}};
`else
   assign w_push_entry   = {bus.dsp_xADDR_slv_id_i, bus.m_WLAST_i, bus.m_WDATA_i};
`endif

   dsp_wdata_channel_skid_buffer_2 #(
      .WIDTH (ENTRY_W)
   ) u_skid (
      .i_clk       (ACLK_i),
      .i_rst_n     (ARESETn_i),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .o_full      (w_full),
      .o_pop_valid (w_head_valid),
      .i_pop_ready (w_sel_ready),
      .o_pop_data  (w_head),
      .o_count     (w_count)
   );

   assign w_head_id   = w_head[ENTRY_W-1 -: SLV_ID_W];
   assign w_head_last = w_head[ENTRY_W-SLV_ID_W-1];
   assign w_head_data = w_head[DATA_WIDTH-1:0];

   always_comb begin
      w_onehot = '0;
      for (int k = 0; k < SLV_AMT; k++) begin
         w_onehot[k] = w_head_valid & (w_head_id == SLV_ID_W'(k));
      end
   end

   // Only the tagged slave's ready can retire the head beat.
   assign w_sel_ready = |(w_onehot & bus.sa_WREADY_i);

   assign bus.sa_WVALID_o      = w_onehot;
   assign bus.sa_WDATA_o       = {SLV_AMT{w_head_data}};
   assign bus.sa_WLAST_o       = {SLV_AMT{w_head_last}};
   assign bus.dsp_WDATA_pend_o = w_count;

endmodule

// File: tb/tb_dsp_wdata_channel.sv
// Randomized bench for dsp_wdata_channel against a queue model of the tagged W stream.
module tb_dsp_wdata_channel;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   // Model entry: {slv_id, last, data}
   logic [33:0] exp_q[$];

   dsp_wdata_channel_if #(.SLV_AMT(2), .DATA_WIDTH(32)) u_if ();

   dsp_wdata_channel #(
      .SLV_AMT    (2),
      .DATA_WIDTH (32)
   ) u_dut (
      .ACLK_i    (clk),
      .ARESETn_i (rst_n),
      .bus       (u_if)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [1:0] exp_v;
      exp_v = (exp_q.size() != 0) ? (2'b01 << exp_q[0][33]) : 2'b00;
      check({tag, "_pend"}, 64'(u_if.dsp_WDATA_pend_o), 64'(exp_q.size()));
      check({tag, "_valid"}, 64'(u_if.sa_WVALID_o), 64'(exp_v));
      if (exp_q.size() != 0) begin
         check({tag, "_data0"}, 64'(u_if.sa_WDATA_o[31:0]), 64'(exp_q[0][31:0]));
         check({tag, "_data1"}, 64'(u_if.sa_WDATA_o[63:32]), 64'(exp_q[0][31:0]));
         check({tag, "_last"}, 64'(u_if.sa_WLAST_o), 64'({2{exp_q[0][32]}}));
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic [31:0] d, input logic l,
                        input logic id, input logic dis, input logic [1:0] sr);
      u_if.m_WVALID_i          = v;
      u_if.m_WDATA_i           = d;
      u_if.m_WLAST_i           = l;
      u_if.dsp_xADDR_slv_id_i  = id;
      u_if.dsp_xADDR_disable_i = dis;
      u_if.sa_WREADY_i         = sr;
`ifdef DSP_WDATA_STRB_EN
      u_if.m_WSTRB_i           = '1;
`endif
   endtask

   // One clock cycle, entered and left on a falling edge.
   task automatic step(input string tag, input logic v, input logic [31:0] d, input logic l,
                       input logic id, input logic dis, input logic [1:0] sr);
      logic exp_rdy;
      logic do_push;
      logic do_pop;
      check_outputs(tag);
      drive(v, d, l, id, dis, sr);
      #1;
      exp_rdy = (exp_q.size() < 2) && !dis;
      check({tag, "_wready"}, 64'(u_if.m_WREADY_o), 64'(exp_rdy));
      do_push = v & exp_rdy;
      do_pop  = (exp_q.size() != 0) && sr[exp_q[0][33]];
      @(posedge clk);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({id, l, d});
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
      @(negedge clk);
      @(negedge clk);
      check_outputs("reset");
      #1;
      check("reset_wready", 64'(u_if.m_WREADY_o), 64'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00);
      #1;
      check("reset_wready_dis", 64'(u_if.m_WREADY_o), 64'd0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;

      // Single beat to slave 1
      step("single_push", 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0, 2'b00);
      check("single_onehot", 64'(u_if.sa_WVALID_o), 64'h2);
      step("single_pop", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b10);
      step("single_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);

      // Backpressure: three offered beats, slaves stalled, then release
      for (int i = 0; i < 3; i++)
         step("bp_fill", 1'b1, 32'h1000 + 32'(i), (i == 2), 1'b0, 1'b0, 2'b00);
      check("bp_pend_full", 64'(u_if.dsp_WDATA_pend_o), 64'd2);
      for (int i = 0; i < 4; i++)
         step("bp_drain", (i == 0), 32'h1002, 1'b1, 1'b0, 1'b0, 2'b11);

      // Streaming 8-beat burst at full rate
      for (int i = 0; i < 9; i++)
         step("stream", (i < 8), 32'h2000 + 32'(i), (i == 7), 1'b1, 1'b0, 2'b11);

      // Slave switch: burst A to slave 0 stalled, burst B to slave 1 queued behind it
      step("sw_a0", 1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 2'b10);
      step("sw_a1", 1'b1, 32'hA000_0001, 1'b1, 1'b0, 1'b0, 2'b10);
      step("sw_b0_blk", 1'b1, 32'hB000_0000, 1'b1, 1'b1, 1'b0, 2'b10);
      check("sw_hold_slv0", 64'(u_if.sa_WVALID_o), 64'h1);
      for (int i = 0; i < 4; i++)
         step("sw_drain", (i == 0), 32'hB000_0000, 1'b1, 1'b1, 1'b0, 2'b01 | ((i >= 1) ? 2'b10 : 2'b00));

      // Disable blocks pushes but lets buffered beats drain
      step("dis_fill", 1'b1, 32'hD000_0001, 1'b1, 1'b1, 1'b0, 2'b00);
      step("dis_block", 1'b1, 32'hD000_0002, 1'b1, 1'b0, 1'b1, 2'b00);
      step("dis_drain", 1'b1, 32'hD000_0003, 1'b1, 1'b0, 1'b1, 2'b10);
      step("dis_empty", 1'b1, 32'hD000_0004, 1'b1, 1'b0, 1'b1, 2'b11);

      // Asynchronous reset with two beats buffered
      step("rst_fill0", 1'b1, 32'hEEEE_0000, 1'b0, 1'b1, 1'b0, 2'b00);
      step("rst_fill1", 1'b1, 32'hEEEE_0001, 1'b1, 1'b1, 1'b0, 2'b00);
      check("rst_pre_pend", 64'(u_if.dsp_WDATA_pend_o), 64'd2);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("rst_async_valid", 64'(u_if.sa_WVALID_o), 64'd0);
      check("rst_async_pend", 64'(u_if.dsp_WDATA_pend_o), 64'd0);
      check("rst_async_wready", 64'(u_if.m_WREADY_o), 64'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++)
         step("rst_no_stale", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b11);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step("rand",
              ($urandom_range(0, 3) != 0),
              $urandom,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0),
              2'($urandom_range(0, 3)));
      end
      for (int i = 0; i < 3; i++)
         step("final_drain", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b11);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dsp_wdata_channel.md
Name: dsp_wdata_channel

Overview:
- Write-data dispatcher that sits directly downstream of the per-master address-channel dispatcher.
- Accepts W beats from one master and tags each accepted beat with the slave ID supplied by the address dispatcher's order FIFO head.
- Buffers tagged beats in a 2-entry skid buffer and presents them to the per-slave arbitration inputs.
- Registered boundary on the W path gives full throughput; the address dispatcher may pop its FIFO on the last master-side beat while buffered beats keep their own slave tag.

Parameters:
SLV_AMT, 2, number of slaves
SLV_ID_W, $clog2(SLV_AMT), width of slave index
DATA_WIDTH, 32, WDATA width
BUF_DEPTH, 2, skid entries (fixed at 2; other values unsupported)

Ports:
ACLK_i  in  1  clock
ARESETn_i  in  1  asynchronous active-low reset
m_WDATA_i  in  DATA_WIDTH  master write data
m_WLAST_i  in  1  last beat of burst
m_WVALID_i  in  1  master beat valid
m_WREADY_o  out  1  beat accepted when high with m_WVALID_i
dsp_xADDR_slv_id_i  in  SLV_ID_W  target slave of oldest open write burst
dsp_xADDR_disable_i  in  1  high = no open write burst (order FIFO empty)
sa_WREADY_i  in  SLV_AMT  per-slave arbitration ready
sa_WDATA_o  out  DATA_WIDTH*SLV_AMT  data replicated to every slave slice
sa_WLAST_o  out  SLV_AMT  WLAST replicated
sa_WVALID_o  out  SLV_AMT  one-hot valid toward the tagged slave
dsp_WDATA_pend_o  out  2  beats currently buffered (0..2)

Behaviour:
- Buffer entry = {slv_id, last, data}. Pointers wr_ptr/rd_ptr are 1 bit each. Count state is EMPTY(0), ONE(1), FULL(2).
- m_WREADY_o = ~FULL & ~dsp_xADDR_disable_i. It is combinational and does not depend on m_WVALID_i.
- push = m_WVALID_i & m_WREADY_o. Entry is written at wr_ptr with slv_id = dsp_xADDR_slv_id_i sampled in the push cycle.
- Head = entry[rd_ptr], valid when state != EMPTY.
- sa_WVALID_o[k] = valid & (head.slv_id == k); all other bits are 0.
- sa_WDATA_o and sa_WLAST_o: every slice carries head.data and head.last.
- pop = valid & sa_WREADY_i[head.slv_id]. sa_WREADY_i bits of non-selected slaves are ignored.
- Latency: a beat accepted in cycle N appears on sa_WVALID_o in cycle N+1 (no combinational path master→slave).
- State transitions:
  - EMPTY: push → ONE.
  - ONE: push & ~pop → FULL; pop & ~push → EMPTY; push & pop → ONE (pointers both advance).
  - FULL: no push possible; pop → ONE.
- Holding: once sa_WVALID_o is asserted, head data/last/slv_id stay stable until pop (AXI valid-hold rule).
- Slave ID change across bursts: when the last beat of burst A and the first beat of burst B (different slave) are both buffered, the bursts go out strictly in order; sa_WVALID_o switches one-hot target exactly on the pop of A's last beat.
- dsp_xADDR_disable_i high blocks new pushes but does not affect draining of buffered beats.
- dsp_WDATA_pend_o = state count, registered.
- Reset (async, mid-operation included) forces:
  - state EMPTY, pointers 0, sa_WVALID_o=0, dsp_WDATA_pend_o=0.
  - Buffered beats are discarded.
  - m_WREADY_o then follows dsp_xADDR_disable_i only.
- Data storage is not reset.
- The block performs no WLAST-vs-AxLEN checking; burst accounting belongs to the address dispatcher.

Optional Feature:
- Macro DSP_WDATA_STRB_EN.
- When defined, the block adds:
  - port m_WSTRB_i [DATA_WIDTH/8] (input).
  - port sa_WSTRB_o [DATA_WIDTH/8*SLV_AMT] (output).
  - WSTRB is stored in each entry and replicated like data.
- When undefined: no strobe ports or storage; downstream assumes all bytes valid.

Decomposition:
- Shared interconnect package holds:
  - SLV_ID_W derivation.
  - The W entry packing order {slv_id, last, strb?, data}.
  - Skid-state encoding EMPTY/ONE/FULL.
- One sub-module is natural: skid_buffer_2 (generic 2-entry valid/ready buffer with payload width parameter). Slave tagging and one-hot demux stay in dsp_wdata_channel.

Test Plan:
- Single beat: disable=0, slv_id=1, push D=0xA5A5A5A5 last=1 → next cycle sa_WVALID_o=2'b10, sa_WDATA slice1=0xA5A5A5A5; pop with sa_WREADY_i=2'b10 → pend returns 0.
- Backpressure: 3 consecutive beats, sa_WREADY_i=0 → m_WREADY_o drops after 2nd accept, pend=2; release ready → beats exit in order, no loss or duplication.
- Streaming: 8-beat burst with sa_WREADY_i always 1 → one beat per cycle, m_WREADY_o never deasserts, pend stays ≤1.
- Slave switch: burst A (slv 0, 2 beats) then burst B (slv 1) while slave 0 is stalled → sa_WVALID_o=01 until A's last pop, then 10 the next cycle with B data.
- Disable: disable=1 with m_WVALID_i=1 → m_WREADY_o=0, no push; buffered beats still drain.
- Reset mid-flight: pend=2, assert ARESETn_i low asynchronously → sa_WVALID_o=0, pend=0 immediately, no stale beat after release.
